// File: rtl/act_stream_packer_if.sv
// Bus bundles for act_stream_packer: the en-qualified activation byte stream
// and the valid/ready word write port into the feature-map buffer.

interface act_stream_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_en;
    logic              in_ready;

    modport master (output in_data, output in_en, input in_ready);
    modport slave  (input in_data, input in_en, output in_ready);
endinterface

interface act_wr_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = 10
);
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W*LANES-1:0]   wr_data;
    logic [LANES-1:0]          wr_mask;
    logic                      wr_ready;

    modport master (output wr_en, output wr_addr, output wr_data, output wr_mask,
                    input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, input wr_mask,
                    output wr_ready);
endinterface

// File: rtl/act_stream_packer.sv
// Packs relu activation bytes into LANES-wide words and writes one frame into
// the feature-map buffer. Define ACT_ZERO_COUNT_EN to add the zero_cnt output.

module act_stream_packer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  frame_len,
    act_stream_if.slave       stream,
    act_wr_if.master          wr,
    output logic              busy,
    output logic              done,
`ifdef ACT_ZERO_COUNT_EN
    output logic [LEN_W-1:0]  zero_cnt,
`endif
    output logic              overflow
);
    localparam int unsigned WORD_W = DATA_W * LANES;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} state_t;

    state_t              state, state_nxt;
    logic [LEN_W-1:0]    len_q, len_nxt;
    logic [LEN_W-1:0]    byte_q, byte_nxt;
    logic [LANE_W-1:0]   lane_q, lane_nxt;
    logic [WORD_W-1:0]   word_q, word_nxt;
    logic [1:0]          cnt_q, cnt_nxt;
    logic [WORD_W-1:0]   d0_q, d0_nxt, d1_q, d1_nxt;
    logic [LANES-1:0]    m0_q, m0_nxt, m1_q, m1_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic                ovf_q, ovf_nxt;
    logic                ready_q, ready_nxt;
    logic                wr_en_q, wr_en_nxt;
    logic                busy_q, busy_nxt;
    logic                done_q, done_nxt;
    logic                accept, last, push, pop;
    logic [WORD_W-1:0]   fill_word;
    logic [LANES-1:0]    fill_mask;
`ifdef ACT_ZERO_COUNT_EN
    logic [LEN_W-1:0]    zero_q, zero_nxt;
`endif

    // Next-state, queue and output-register computation
    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        byte_nxt  = byte_q;
        lane_nxt  = lane_q;
        word_nxt  = word_q;
        cnt_nxt   = cnt_q;
        d0_nxt    = d0_q;
        d1_nxt    = d1_q;
        m0_nxt    = m0_q;
        m1_nxt    = m1_q;
        addr_nxt  = addr_q;
        ovf_nxt   = ovf_q;
`ifdef ACT_ZERO_COUNT_EN
        zero_nxt  = zero_q;
`endif
        accept    = stream.in_en && ready_q;
        last      = accept && (LEN_W'(byte_q + 1'b1) == len_q);
        push      = accept && ((lane_q == LANE_W'(LANES - 1)) || last);
        pop       = (cnt_q != 2'd0) && wr.wr_ready;
        fill_word = word_q | (WORD_W'(stream.in_data) << (DATA_W * lane_q));
        for (int i = 0; i < LANES; i++) begin
            fill_mask[i] = (i <= int'(lane_q));
        end

        unique case (state)
            IDLE: begin
                if (start) begin
                    ovf_nxt   = 1'b0;
                    addr_nxt  = base_addr;
                    byte_nxt  = '0;
                    lane_nxt  = '0;
                    word_nxt  = '0;
                    len_nxt   = frame_len;
`ifdef ACT_ZERO_COUNT_EN
                    zero_nxt  = '0;
`endif
                    state_nxt = (frame_len == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    byte_nxt = LEN_W'(byte_q + 1'b1);
`ifdef ACT_ZERO_COUNT_EN
                    if (stream.in_data == '0) zero_nxt = LEN_W'(zero_q + 1'b1);
`endif
                    if (push) begin
                        lane_nxt = '0;
                        word_nxt = '0;
                    end else begin
                        lane_nxt = LANE_W'(lane_q + 1'b1);
                        word_nxt = fill_word;
                    end
                    if (last) state_nxt = FLUSH;
                end else if (stream.in_en) begin
                    ovf_nxt = 1'b1;
                end
            end
            FLUSH: if (cnt_q == 2'd0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Two-entry queue: entry 0 is the head driving the write port
        if (pop) begin
            addr_nxt = ADDR_W'(addr_q + 1'b1);
            d0_nxt   = d1_q;
            m0_nxt   = m1_q;
        end
        if (push) begin
            if ((cnt_q - {1'b0, pop}) == 2'd0) begin
                d0_nxt = fill_word;
                m0_nxt = fill_mask;
            end else begin
                d1_nxt = fill_word;
                m1_nxt = fill_mask;
            end
        end
        cnt_nxt = 2'(cnt_q + {1'b0, push} - {1'b0, pop});

        ready_nxt = (state_nxt == COLLECT) && (cnt_nxt < 2'd2);
        wr_en_nxt = (cnt_nxt != 2'd0);
        busy_nxt  = (state_nxt == COLLECT) || (state_nxt == FLUSH);
        done_nxt  = (state_nxt == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            len_q   <= '0;
            byte_q  <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            m0_q    <= '0;
            m1_q    <= '0;
            addr_q  <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ACT_ZERO_COUNT_EN
            zero_q  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            len_q   <= len_nxt;
            byte_q  <= byte_nxt;
            lane_q  <= lane_nxt;
            word_q  <= word_nxt;
            cnt_q   <= cnt_nxt;
            d0_q    <= d0_nxt;
            d1_q    <= d1_nxt;
            m0_q    <= m0_nxt;
            m1_q    <= m1_nxt;
            addr_q  <= addr_nxt;
            ovf_q   <= ovf_nxt;
            ready_q <= ready_nxt;
            wr_en_q <= wr_en_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
`ifdef ACT_ZERO_COUNT_EN
            zero_q  <= zero_nxt;
`endif
        end
    end

    assign stream.in_ready = ready_q;
    assign wr.wr_en        = wr_en_q;
    assign wr.wr_addr      = addr_q;
    assign wr.wr_data      = d0_q;
    assign wr.wr_mask      = m0_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign overflow        = ovf_q;
`ifdef ACT_ZERO_COUNT_EN
    assign zero_cnt        = zero_q;
`endif

endmodule

// File: tb/tb_act_stream_packer.sv
// Self-checking bench for act_stream_packer: directed frames plus randomized
// frames compared against a byte-list model of the packed write stream.

module tb_act_stream_packer;
    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [9:0]  a;
        logic [63:0] d;
        logic [7:0]  m;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [15:0] frame_len;
    logic        busy, done, overflow;
`ifdef ACT_ZERO_COUNT_EN
    logic [15:0] zero_cnt;
`endif

    act_stream_if #(.DATA_W(8)) stream ();
    act_wr_if #(.DATA_W(8), .LANES(8), .ADDR_W(10)) wr ();

    act_stream_packer #(.DATA_W(8), .LANES(8), .ADDR_W(10), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .frame_len(frame_len), .stream(stream), .wr(wr), .busy(busy),
        .done(done),
`ifdef ACT_ZERO_COUNT_EN
        .zero_cnt(zero_cnt),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    wr_t got[$];
    int  done_cnt = 0;
    int  wr_en_seen = 0;
    int  done0 = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    // Write-port and done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (wr.wr_en && wr.wr_ready) got.push_back('{wr.wr_addr, wr.wr_data, wr.wr_mask});
            if (done) done_cnt++;
            if (wr.wr_en) wr_en_seen++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_data(input byte_q_t b, input int j);
        logic [63:0] w = '0;
        for (int l = 0; l < 8; l++)
            if (j * 8 + l < b.size()) w[l*8 +: 8] = b[j*8 + l];
        return w;
    endfunction

    function automatic logic [7:0] exp_mask(input byte_q_t b, input int j);
        logic [7:0] m = '0;
        for (int l = 0; l < 8; l++)
            if (j * 8 + l < b.size()) m[l] = 1'b1;
        return m;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_in_ready"}, stream.in_ready, 0);
        chk({pfx, "_wr_en"}, wr.wr_en, 0);
        chk({pfx, "_wr_addr"}, wr.wr_addr, 0);
        chk({pfx, "_wr_data"}, wr.wr_data, 0);
        chk({pfx, "_wr_mask"}, wr.wr_mask, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_overflow"}, overflow, 0);
    endtask

    task automatic begin_frame(input logic [9:0] base, input int len);
        got.delete();
        done0 = done_cnt;
        start = 1'b1;
        base_addr = base;
        frame_len = 16'(len);
        tick;
        start = 1'b0;
    endtask

    // Reactive byte source: only presents a byte while in_ready is high
    task automatic feed(input byte_q_t b, input int ready_pct, input int en_pct,
                        input int pulse_at);
        int idx = 0;
        int g = 0;
        bit took;
        bit pulsed = 0;
        while (idx < b.size() && g < 5000) begin
            took = 0;
            stream.in_en = 1'b0;
            wr.wr_ready = ($urandom_range(99) < ready_pct);
            if (idx == pulse_at && !pulsed) begin
                start = 1'b1; base_addr = 10'h200; frame_len = 16'd3; pulsed = 1;
            end else start = 1'b0;
            if (stream.in_ready && $urandom_range(99) < en_pct) begin
                stream.in_en = 1'b1;
                stream.in_data = b[idx];
                took = 1;
            end
            tick;
            if (took) idx++;
            g++;
        end
        stream.in_en = 1'b0;
        start = 1'b0;
        chk("feed_timeout", g < 5000, 1);
    endtask

    task automatic end_frame(input logic [9:0] base, input byte_q_t b);
        int g = 0;
        int nw;
        int zeros = 0;
        wr.wr_ready = 1'b1;
        stream.in_en = 1'b0;
        while (done_cnt == done0 && g < 300) begin
            tick;
            g++;
        end
        chk("done_timeout", done_cnt != done0, 1);
        tick;
        chk("done_once", done_cnt - done0, 1);
        chk("busy_after_done", busy, 0);
        nw = (b.size() + 7) / 8;
        chk("write_count", got.size(), nw);
        for (int j = 0; j < nw && j < got.size(); j++) begin
            chk($sformatf("wr%0d_addr", j), got[j].a, 10'(base + j));
            chk($sformatf("wr%0d_data", j), got[j].d, exp_data(b, j));
            chk($sformatf("wr%0d_mask", j), got[j].m, exp_mask(b, j));
        end
        foreach (b[i]) if (b[i] == 8'h00) zeros++;
`ifdef ACT_ZERO_COUNT_EN
        chk("zero_cnt", zero_cnt, zeros);
`endif
    endtask

    initial begin
        byte_q_t b;
        byte_q_t rest;
        int seen0;
        int len;

        reset = 1'b1; start = 1'b0; base_addr = '0; frame_len = '0;
        stream.in_data = '0; stream.in_en = 1'b0; wr.wr_ready = 1'b1;
        repeat (3) tick;
        reset = 1'b0;
        tick;
        check_reset_outputs("reset");
`ifdef ACT_ZERO_COUNT_EN
        chk("reset_zero_cnt", zero_cnt, 0);
`endif

        // Full frame, no stall
        b = {};
        for (int i = 1; i <= 16; i++) b.push_back(8'(i));
        begin_frame(10'h010, 16);
        feed(b, 100, 100, -1);
        end_frame(10'h010, b);
        if (got.size() == 2) begin
            chk("full_word0", got[0].d, 64'h0807060504030201);
            chk("full_word1", got[1].d, 64'h100F0E0D0C0B0A09);
        end
        chk("full_overflow", overflow, 0);

        // Partial final word
        b = {};
        for (int i = 0; i < 11; i++) b.push_back(8'(8'hA0 + i));
        begin_frame(10'h100, 11);
        feed(b, 100, 100, -1);
        end_frame(10'h100, b);
        if (got.size() == 2) begin
            chk("partial_addr", got[1].a, 10'h101);
            chk("partial_data", got[1].d, 64'h0000000000AAA9A8);
            chk("partial_mask", got[1].m, 8'h07);
        end

        // Backpressure with address wrap
        b = {};
        begin_frame(10'h3FF, 24);
        wr.wr_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            stream.in_en = 1'b1;
            stream.in_data = 8'(i);
            b.push_back(8'(i));
            tick;
        end
        stream.in_data = 8'd17;
        chk("bp_in_ready_low", stream.in_ready, 0);
        tick;
        stream.in_en = 1'b0;
        chk("bp_overflow_set", overflow, 1);
        chk("bp_hold_addr0", wr.wr_addr, 10'h3FF);
        chk("bp_hold_data0", wr.wr_data, 64'h0807060504030201);
        tick;
        chk("bp_hold_addr1", wr.wr_addr, 10'h3FF);
        chk("bp_hold_data1", wr.wr_data, 64'h0807060504030201);
        chk("bp_no_writes", got.size(), 0);
        rest = {};
        for (int i = 0; i < 8; i++) rest.push_back(8'(8'h81 + i));
        feed(rest, 100, 100, -1);
        b = {b, rest};
        end_frame(10'h3FF, b);
        chk("bp_overflow_sticky", overflow, 1);

        // in_en in IDLE is ignored
        stream.in_en = 1'b1;
        stream.in_data = 8'h55;
        repeat (3) tick;
        stream.in_en = 1'b0;
        chk("idle_in_ready", stream.in_ready, 0);
        chk("idle_busy", busy, 0);

        // Zero-length frame
        seen0 = wr_en_seen;
        begin_frame(10'h0AA, 0);
        chk("zero_len_done", done, 1);
        chk("zero_len_ovf_cleared", overflow, 0);
        tick;
        chk("zero_len_done_low", done, 0);
        tick;
        chk("zero_len_no_wr_en", wr_en_seen - seen0, 0);
        chk("zero_len_done_once", done_cnt - done0, 1);

        // start while busy is ignored
        b = {};
        for (int i = 0; i < 16; i++) b.push_back(8'($urandom_range(255)));
        begin_frame(10'h020, 16);
        feed(b, 100, 100, 4);
        end_frame(10'h020, b);

        // Randomized frames against the model
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(40, 1);
            b = {};
            for (int i = 0; i < len; i++)
                b.push_back(($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255)));
            begin_frame(10'($urandom_range(1023)), len);
            feed(b, 55, 70, -1);
            end_frame(base_addr, b);
            chk($sformatf("rand%0d_overflow", f), overflow, 0);
        end

        // Reset mid-frame
        begin_frame(10'h040, 16);
        for (int i = 0; i < 5; i++) begin
            stream.in_en = 1'b1;
            stream.in_data = 8'(8'hC0 + i);
            tick;
        end
        stream.in_en = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick;
        reset = 1'b0;
        got.delete();
        repeat (10) tick;
        chk("midrst_no_writes", got.size(), 0);
        b = {};
        for (int i = 0; i < 8; i++) b.push_back(8'(8'h31 + i));
        begin_frame(10'h050, 8);
        feed(b, 100, 100, -1);
        end_frame(10'h050, b);

`ifdef ACT_ZERO_COUNT_EN
        b = {8'h00, 8'h05, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h01, 8'h00};
        begin_frame(10'h060, 8);
        feed(b, 100, 100, -1);
        end_frame(10'h060, b);
        chk("zc_five", zero_cnt, 5);
        b = {8'h11, 8'h22};
        begin_frame(10'h070, 2);
        chk("zc_cleared_on_start", zero_cnt, 0);
        feed(b, 100, 100, -1);
        end_frame(10'h070, b);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/act_stream_packer.md
Name: act_stream_packer

Overview:
- Receiving end of the 8-bit `en`-qualified activation stream that the relu stage drives.
- Collects post-activation bytes, packs LANES bytes into one wide word and writes words sequentially into the output feature-map buffer through a valid/ready write port.
- Frame-based: each `start` writes exactly `frame_len` activations beginning at `base_addr`, then pulses `done`.

Parameters:
- DATA_W, 8, width of one activation.
- LANES, 8, activations per packed word; wr_data is DATA_W*LANES bits wide.
- ADDR_W, 10, buffer word-address width.
- LEN_W, 16, width of frame_len.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle frame start; honoured only in IDLE.
- base_addr  input  ADDR_W  first word address of the frame; latched on start.
- frame_len  input  LEN_W  activations in the frame; latched on start.
- in_data  input  DATA_W  activation byte (relu output).
- in_en  input  1  in_data valid this cycle.
- in_ready  output  1  packer can accept a byte this cycle.
- wr_en  output  1  write request valid.
- wr_addr  output  ADDR_W  word address of the current write.
- wr_data  output  DATA_W*LANES  packed word; lane 0 in bits [DATA_W-1:0].
- wr_mask  output  LANES  per-lane byte enable.
- wr_ready  input  1  buffer accepts the write this cycle.
- busy  output  1  high in COLLECT and FLUSH.
- done  output  1  one-cycle pulse at frame completion.
- overflow  output  1  sticky: a byte was presented while in_ready was low in COLLECT.

Behaviour:
- Reset values:
  - State: IDLE.
  - Outputs: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, wr_mask=0, busy=0, done=0, overflow=0.
  - Counters zero; queue empty.
- Reset mid-frame: reset is asynchronous and discards all partial and queued data. No write is issued after reset deasserts.
- State machine:
  - IDLE -> COLLECT on start with frame_len>0.
  - IDLE -> DONE on start with frame_len==0; no writes are issued.
  - COLLECT -> FLUSH the cycle after the frame_len-th byte is accepted.
  - FLUSH -> DONE when the queue is empty.
  - DONE -> IDLE after exactly one cycle; done=1 only in DONE.
- start handling:
  - start outside IDLE is ignored.
  - start in IDLE clears overflow, loads the word address from base_addr, and clears the lane and byte counters.
- Accept rule:
  - A byte is accepted when in_en && in_ready.
  - in_ready = (state==COLLECT) && (queue count<2). in_ready does not depend on wr_ready.
  - Accepted byte goes into lane = lane counter, which increments and wraps at LANES.
- Word push:
  - A word is pushed to the 2-entry queue when lane LANES-1 is filled, or when the last byte of the frame is accepted.
  - Full word: wr_mask = all ones.
  - Partial final word with k lanes filled: wr_mask = (1<<k)-1, and unused lanes are zero.
  - The partial word is pushed the same cycle as the final byte.
  - Lane register and counter clear after every push.
- Write port:
  - wr_en = queue non-empty; wr_addr/wr_data/wr_mask come from the queue head.
  - A write completes on wr_en && wr_ready; the head pops and the address increments by 1, wrapping modulo 2^ADDR_W.
  - Latency: the byte that completes a word gives wr_en=1 on the next cycle.
  - Simultaneous push and pop is legal and keeps the count unchanged.
  - Outputs hold stable while wr_en && !wr_ready.
- Error and ignore rules:
  - in_en && !in_ready in COLLECT sets overflow; the byte is dropped and not counted.
  - in_en in any other state is ignored and does not set overflow.
- Width rules:
  - The byte counter is LEN_W bits and compares against the latched frame_len.
  - Total words issued = ceil(frame_len/LANES).

Optional Feature:
- Macro: ACT_ZERO_COUNT_EN.
- Defined:
  - Adds output zero_cnt [LEN_W-1:0].
  - zero_cnt counts accepted bytes equal to 0 in the current frame.
  - It clears on accepted start and holds its value after done until the next start. Reset value is 0.
- Undefined: no zero_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Full frame, no stall: reset, start with base_addr=0x010, frame_len=16, LANES=8, bytes 0x01..0x10 with in_en continuous, wr_ready=1.
  - Two writes: addr 0x010 data 0x0807060504030201 mask 0xFF, then addr 0x011 data 0x100F0E0D0C0B0A09 mask 0xFF.
  - done pulses once; overflow=0.
- Partial final word: frame_len=11, bytes 0xA0..0xAA.
  - Second write at base+1 has data 0x0000000000AAA9A8, mask 0x07.
- Backpressure: wr_ready=0, feed 24 bytes continuously.
  - in_ready drops after the 16th byte (queue full).
  - The 17th byte with in_en=1 sets overflow=1 and is dropped.
  - Releasing wr_ready drains the two queued words in order.
- Zero-length and ignore cases:
  - start with frame_len=0: done pulses the cycle after start; wr_en is never asserted.
  - start asserted while busy: ignored, frame continues unchanged.
  - in_en high in IDLE: no effect.
- Reset mid-frame: assert reset after 5 bytes of a frame_len=16 frame.
  - All outputs go to reset values immediately; no writes follow.
  - A new start with frame_len=8 produces one clean word.
- ACT_ZERO_COUNT_EN defined: frame_len=8 with bytes 00,05,00,00,7F,00,01,00.
  - zero_cnt=5 at done; it resets to 0 on the next start.
